seg_adder_sequencer: RTL and testbench

//  Multi-cycle wide adder controller. Adds two WIDTH-bit operands one SEG-bit segment per cycle

---
 rtl/seg_adder_sequencer.sv | 222 ++++++++++++++++++++++
 tb/tb_seg_adder_sequencer.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/seg_adder_sequencer.sv
// ---------------------------------------------------------------------------
// seg_adder_sequencer
//
// Multi-cycle wide adder. A WIDTH-bit addition is performed one SEG-bit
// segment per clock through a single shared carry_lookahead_adder, with the
// carry held in a register between segments. In approximate mode the low
// APPROX_BITS are produced as a|b (lower-part-OR adder) and the first exact
// segment takes its carry-in from the AND of the top approximate bit pair.
//
// Ports
//   clk_i        clock, all state on the rising edge
//   rst_i        asynchronous reset, active-high
//   in_valid_i   operand beat valid
//   in_ready_o   block can accept operands (state IDLE)
//   add1_i       operand A
//   add2_i       operand B
//   carry_i      carry-in, honoured in exact mode (or when APPROX_BITS = 0)
//   exact_i      1 = exact add, 0 = lower-part-OR approximation
//   out_valid_o  result valid (state DONE)
//   out_ready_i  consumer accepts result
//   result_o     {carry_out, sum}
//   busy_o       high whenever the block is not IDLE
// ---------------------------------------------------------------------------

// Combinational carry-lookahead adder: every carry is a flat sum of
// generate/propagate products, no carry chain between bit positions.
//   a, b  addends
//   cin   carry-in
//   sum   {carry_out, sum}
module carry_lookahead_adder #(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH:0]   sum
);

  logic [WIDTH-1:0] g;
  logic [WIDTH-1:0] p;
  logic [WIDTH:0]   c;
  logic             run_p;
  logic             acc;

  always_comb begin
    g     = a & b;
    p     = a ^ b;
    c     = '0;
    run_p = 1'b1;
    acc   = 1'b0;
    c[0]  = cin;
    // c[i+1] = g[i] | p[i]g[i-1] | ... | p[i]..p[0]cin
    for (int unsigned i = 0; i < WIDTH; i++) begin
      run_p = 1'b1;
      acc   = 1'b0;
      for (int unsigned k = 0; k <= i; k++) begin
        acc   = acc | (run_p & g[i-k]);
        run_p = run_p & p[i-k];
      end
      c[i+1] = acc | (run_p & cin);
    end
    sum = {c[WIDTH], p ^ c[WIDTH-1:0]};
  end

endmodule

module seg_adder_sequencer #(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned SEG         = 8,
  parameter int unsigned APPROX_BITS = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] add1_i,
  input  logic [WIDTH-1:0] add2_i,
  input  logic             carry_i,
  input  logic             exact_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH:0]   result_o,
  output logic             busy_o
);

  localparam int unsigned NSEG        = WIDTH / SEG;
  localparam int unsigned APPROX_SEGS = APPROX_BITS / SEG;
  localparam int unsigned IDX_W       = (NSEG > 1) ? $clog2(NSEG) : 1;
  localparam int unsigned LOA_BIT     = (APPROX_BITS > 0) ? APPROX_BITS - 1 : 0;

  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NSEG - 1);
  localparam logic [IDX_W-1:0] APPROX_IDX = IDX_W'(APPROX_SEGS);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t           state;
  logic [IDX_W-1:0] seg_idx;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             exact_q;
  logic             carry_q;
  logic             loa_cin_q;
  logic [WIDTH:0]   result_q;
  logic             in_ready_q;
  logic             out_valid_q;
  logic             busy_q;

  logic [SEG-1:0]   a_seg;
  logic [SEG-1:0]   b_seg;
  logic             in_approx;
  logic             first_exact;
  logic             cla_cin;
  logic [SEG:0]     cla_sum;
  logic [SEG-1:0]   sum_seg;
  logic             next_carry;

  // Segment select from the latched operands.
  always_comb begin
    a_seg = '0;
    b_seg = '0;
    for (int unsigned k = 0; k < NSEG; k++) begin
      if (seg_idx == IDX_W'(k)) begin
        a_seg = a_q[k*SEG +: SEG];
        b_seg = b_q[k*SEG +: SEG];
      end
    end
  end

  // The approximate region occupies the first APPROX_SEGS segments; the
  // segment right after it takes its carry from the top OR'ed bit pair.
  always_comb begin
    in_approx   = !exact_q && (seg_idx < APPROX_IDX);
    first_exact = !exact_q && (APPROX_SEGS != 0) && (seg_idx == APPROX_IDX);
    cla_cin     = first_exact ? loa_cin_q : carry_q;
  end

  carry_lookahead_adder #(
    .WIDTH (SEG)
  ) u_cla (
    .a   (a_seg),
    .b   (b_seg),
    .cin (cla_cin),
    .sum (cla_sum)
  );

  always_comb begin
    sum_seg    = in_approx ? (a_seg | b_seg) : cla_sum[SEG-1:0];
    next_carry = in_approx ? carry_q : cla_sum[SEG];
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state       <= IDLE;
      seg_idx     <= '0;
      a_q         <= '0;
      b_q         <= '0;
      exact_q     <= 1'b0;
      carry_q     <= 1'b0;
      loa_cin_q   <= 1'b0;
      result_q    <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid_i) begin
            a_q        <= add1_i;
            b_q        <= add2_i;
            exact_q    <= exact_i;
            seg_idx    <= '0;
            result_q   <= '0;
            carry_q    <= (exact_i || (APPROX_BITS == 0)) ? carry_i : 1'b0;
            loa_cin_q  <= (APPROX_BITS != 0) ? (add1_i[LOA_BIT] & add2_i[LOA_BIT]) : 1'b0;
            state      <= BUSY;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
          end
        end
        BUSY: begin
          for (int unsigned k = 0; k < NSEG; k++) begin
            if (seg_idx == IDX_W'(k)) begin
              result_q[k*SEG +: SEG] <= sum_seg;
            end
          end
          carry_q <= next_carry;
          if (seg_idx == LAST_IDX) begin
            result_q[WIDTH] <= next_carry;
            state           <= DONE;
            out_valid_q     <= 1'b1;
          end else begin
            seg_idx <= seg_idx + 1'b1;
          end
        end
        DONE: begin
          if (out_ready_i) begin
            state       <= IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
          end
        end
        default: begin
          state       <= IDLE;
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready_o  = in_ready_q;
  assign out_valid_o = out_valid_q;
  assign busy_o      = busy_q;
  assign result_o    = result_q;

endmodule

// File: tb/tb_seg_adder_sequencer.sv
// ---------------------------------------------------------------------------
// tb_seg_adder_sequencer
//
// Directed and randomized stimulus for seg_adder_sequencer at default
// parameters. Expected results come from an arithmetic reference:
// A+B+cin for exact mode, and {A_hi+B_hi+(A[7]&B[7]), A_lo|B_lo} for the
// lower-part-OR mode.
// ---------------------------------------------------------------------------
module tb_seg_adder_sequencer;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned NSEG  = 4;

  logic             clk = 1'b0;
  logic             rst_i;
  logic             in_valid_i;
  logic             in_ready_o;
  logic [WIDTH-1:0] add1_i;
  logic [WIDTH-1:0] add2_i;
  logic             carry_i;
  logic             exact_i;
  logic             out_valid_o;
  logic             out_ready_i;
  logic [WIDTH:0]   result_o;
  logic             busy_o;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  seg_adder_sequencer #(
    .WIDTH       (32),
    .SEG         (8),
    .APPROX_BITS (8)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .add1_i      (add1_i),
    .add2_i      (add2_i),
    .carry_i     (carry_i),
    .exact_i     (exact_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .result_o    (result_o),
    .busy_o      (busy_o)
  );

  function automatic logic [32:0] ref_model(input logic [31:0] a, input logic [31:0] b,
                                            input logic cin, input logic exact);
    logic [24:0] hi;
    if (exact) begin
      return {1'b0, a} + {1'b0, b} + 33'(cin);
    end
    hi = {1'b0, a[31:8]} + {1'b0, b[31:8]} + 25'(a[7] & b[7]);
    return {hi, a[7:0] | b[7:0]};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    check("busy_ready_complement", 64'(busy_o), 64'(!in_ready_o));
  endtask

  task automatic accept(input logic [31:0] a, input logic [31:0] b,
                        input logic cin, input logic ex);
    int n = 0;
    while (!in_ready_o && n < 50) begin
      tick();
      n++;
    end
    check("accept_ready", 64'(in_ready_o), 64'd1);
    add1_i     = a;
    add2_i     = b;
    carry_i    = cin;
    exact_i    = ex;
    in_valid_i = 1'b1;
    tick();
    in_valid_i = 1'b0;
    add1_i     = $urandom;
    add2_i     = $urandom;
    carry_i    = 1'($urandom);
    exact_i    = 1'($urandom);
  endtask

  task automatic wait_result(input string tag, input logic [32:0] exp);
    int n = 0;
    while (!out_valid_o && n < 20) begin
      tick();
      n++;
    end
    check({tag, "_latency"}, 64'(n), 64'(NSEG));
    check({tag, "_result"}, 64'(result_o), 64'(exp));
  endtask

  task automatic handshake(input string tag);
    out_ready_i = 1'b1;
    tick();
    out_ready_i = 1'b0;
    check({tag, "_valid_drop"}, 64'(out_valid_o), 64'd0);
    check({tag, "_ready_back"}, 64'(in_ready_o), 64'd1);
  endtask

  initial begin
    logic [31:0] a;
    logic [31:0] b;
    logic        c;
    logic [32:0] held;

    rst_i       = 1'b1;
    in_valid_i  = 1'b0;
    out_ready_i = 1'b0;
    add1_i      = '0;
    add2_i      = '0;
    carry_i     = 1'b0;
    exact_i     = 1'b1;
    tick();
    tick();
    check("rst_result", 64'(result_o), 64'd0);
    check("rst_out_valid", 64'(out_valid_o), 64'd0);
    check("rst_busy", 64'(busy_o), 64'd0);
    check("rst_in_ready", 64'(in_ready_o), 64'd1);
    rst_i = 1'b0;
    tick();

    // Exact wrap into carry-out.
    accept(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b1);
    check("t1_busy_after_accept", 64'(busy_o), 64'd1);
    wait_result("t1", 33'h1_0000_0000);
    handshake("t1");

    // Lower-part-OR: bit 7 pair carries into the exact part.
    accept(32'h0000_0080, 32'h0000_0080, 1'b0, 1'b0);
    wait_result("t2a", 33'h0_0000_0180);
    handshake("t2a");
    accept(32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0);
    wait_result("t2b", 33'h0);
    handshake("t2b");

    // Carry ripple across every segment.
    accept(32'h7FFF_FFFF, 32'h0000_0000, 1'b1, 1'b1);
    wait_result("t3", 33'h0_8000_0000);
    handshake("t3");

    // Backpressure with a competing operand beat.
    accept(32'h1234_5678, 32'h1111_1111, 1'b1, 1'b1);
    held = 33'h0_2345_678A;
    wait_result("t4", held);
    add1_i     = 32'h0000_0010;
    add2_i     = 32'h0000_0020;
    carry_i    = 1'b0;
    exact_i    = 1'b1;
    in_valid_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t4_hold_result", 64'(result_o), 64'(held));
      check("t4_hold_valid", 64'(out_valid_o), 64'd1);
      check("t4_hold_ready", 64'(in_ready_o), 64'd0);
    end
    out_ready_i = 1'b1;
    tick();
    out_ready_i = 1'b0;
    check("t4_hs_valid", 64'(out_valid_o), 64'd0);
    check("t4_hs_not_taken", 64'(in_ready_o), 64'd1);
    check("t4_idle_result", 64'(result_o), 64'(held));
    tick();
    in_valid_i = 1'b0;
    check("t4_next_taken", 64'(busy_o), 64'd1);
    wait_result("t4_next", 33'h0_0000_0030);
    handshake("t4_next");

    // Reset in the second BUSY cycle.
    accept(32'hDEAD_BEEF, 32'h0BAD_F00D, 1'b1, 1'b1);
    tick();
    #2 rst_i = 1'b1;
    #1;
    check("t5_rst_result", 64'(result_o), 64'd0);
    check("t5_rst_valid", 64'(out_valid_o), 64'd0);
    check("t5_rst_busy", 64'(busy_o), 64'd0);
    check("t5_rst_ready", 64'(in_ready_o), 64'd1);
    #2 rst_i = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("t5_no_partial", 64'(out_valid_o), 64'd0);
    end
    accept(32'd5, 32'd3, 1'b0, 1'b1);
    wait_result("t5_next", 33'h0_0000_0008);
    handshake("t5_next");

    // Randomized streams in both modes with variable consumer delay.
    for (int i = 0; i < 40; i++) begin
      a = $urandom;
      b = $urandom;
      c = 1'($urandom);
      if (i % 5 == 0) b = ~a;
      accept(a, b, c, (i < 20));
      wait_result((i < 20) ? "rnd_exact" : "rnd_approx", ref_model(a, b, c, (i < 20)));
      repeat ($urandom_range(0, 2)) begin
        tick();
        check("rnd_valid_hold", 64'(out_valid_o), 64'd1);
      end
      handshake("rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
